// File: rtl/video_frame_tagger.sv
// Video frame tagger: passes pixels with 1-cycle latency and inserts a per-frame
// header (magic, frame count, previous-frame line statistics) into idle cycles.
// Optional: define FRAME_TAGGER_CHECKSUM_EN to append a pixel-sum word W4.
module video_frame_tagger #(
    parameter logic [15:0] HDR_MAGIC = 16'hA55A,
    parameter int unsigned EXP_WIDTH = 1920
) (
    input  logic        video_clk,
    input  logic        Reset,
    input  logic        video_vs,
    input  logic        video_de,
    input  logic [15:0] video_data,
    output logic        out_de,
    output logic [15:0] out_data,
    output logic        out_hdr,
    output logic [15:0] frame_cnt,
    output logic        hdr_drop
);

    localparam int unsigned DW = 16;
    localparam int unsigned PW = 15;
    localparam logic [PW-1:0] EXP_LEN = PW'(EXP_WIDTH);
`ifdef FRAME_TAGGER_CHECKSUM_EN
    localparam logic [2:0] LAST_IDX = 3'd4;
`else
    localparam logic [2:0] LAST_IDX = 3'd3;
`endif

    typedef enum logic [1:0] {IDLE, HDR, RUN} state_t;

    state_t         state, state_nxt;
    logic [2:0]     hdr_idx, hdr_idx_nxt;
    logic           de_d;
    logic [PW-1:0]  pix_cnt;
    logic [DW-1:0]  line_cnt;
    logic [PW-1:0]  last_len;
    logic           line_err;
    logic [DW-1:0]  snap_lines;
    logic [PW-1:0]  snap_len;
    logic           snap_err;
`ifdef FRAME_TAGGER_CHECKSUM_EN
    logic [DW-1:0]  pix_sum;
    logic [DW-1:0]  snap_sum;
`endif

    logic           line_close_c;
    logic           emit_hdr_c;
    logic           len_bad_c;
    logic [PW-1:0]  pix_inc_c;
    logic [DW-1:0]  line_inc_c;
    logic [DW-1:0]  hdr_word_c;

    assign line_close_c = de_d & ~video_de;
    assign emit_hdr_c   = (state == HDR) & ~video_vs & ~video_de;
    assign len_bad_c    = (pix_cnt != EXP_LEN);
    assign pix_inc_c    = (pix_cnt == '1) ? pix_cnt : pix_cnt + PW'(1);
    assign line_inc_c   = (line_cnt == '1) ? line_cnt : line_cnt + DW'(1);

    // Header word selected by the pending index
    always_comb begin
        hdr_word_c = HDR_MAGIC;
        case (hdr_idx)
            3'd1:    hdr_word_c = frame_cnt;
            3'd2:    hdr_word_c = snap_lines;
            3'd3:    hdr_word_c = {snap_err, snap_len};
`ifdef FRAME_TAGGER_CHECKSUM_EN
            3'd4:    hdr_word_c = snap_sum;
`endif
            default: hdr_word_c = HDR_MAGIC;
        endcase
    end

    always_ff @(posedge video_clk) begin
        if (Reset) begin
            state   <= IDLE;
            hdr_idx <= '0;
        end else begin
            state   <= state_nxt;
            hdr_idx <= hdr_idx_nxt;
        end
    end

    // Frame start restarts the header from any state; pixels stall header emission
    always_comb begin
        state_nxt   = state;
        hdr_idx_nxt = hdr_idx;
        if (video_vs) begin
            state_nxt   = HDR;
            hdr_idx_nxt = '0;
        end else if (emit_hdr_c) begin
            hdr_idx_nxt = hdr_idx + 3'd1;
            if (hdr_idx == LAST_IDX) begin
                state_nxt = RUN;
            end
        end
    end

    always_ff @(posedge video_clk) begin
        if (Reset) begin
            de_d       <= 1'b0;
            pix_cnt    <= '0;
            line_cnt   <= '0;
            last_len   <= '0;
            line_err   <= 1'b0;
            snap_lines <= '0;
            snap_len   <= '0;
            snap_err   <= 1'b0;
            frame_cnt  <= '0;
            hdr_drop   <= 1'b0;
            out_de     <= 1'b0;
            out_data   <= '0;
            out_hdr    <= 1'b0;
        end else begin
            de_d     <= video_de;
            hdr_drop <= video_vs & (state == HDR);

            // An open line keeps counting across the frame boundary
            if (video_de) begin
                pix_cnt <= pix_inc_c;
            end else if (line_close_c) begin
                pix_cnt <= '0;
            end

            if (video_vs) begin
                frame_cnt  <= frame_cnt + DW'(1);
                snap_lines <= line_cnt;
                snap_len   <= last_len;
                snap_err   <= line_err;
                line_cnt   <= line_close_c ? DW'(1) : '0;
                last_len   <= line_close_c ? pix_cnt : '0;
                line_err   <= line_close_c & len_bad_c;
            end else if (line_close_c) begin
                line_cnt <= line_inc_c;
                last_len <= pix_cnt;
                if (len_bad_c) begin
                    line_err <= 1'b1;
                end
            end

            if (video_de) begin
                out_de   <= 1'b1;
                out_data <= video_data;
                out_hdr  <= 1'b0;
            end else if (emit_hdr_c) begin
                out_de   <= 1'b1;
                out_data <= hdr_word_c;
                out_hdr  <= 1'b1;
            end else begin
                out_de  <= 1'b0;
                out_hdr <= 1'b0;
            end
        end
    end

`ifdef FRAME_TAGGER_CHECKSUM_EN
    // Wrapping pixel sum; a pixel on the frame-start cycle belongs to the new frame
    always_ff @(posedge video_clk) begin
        if (Reset) begin
            pix_sum  <= '0;
            snap_sum <= '0;
        end else if (video_vs) begin
            snap_sum <= pix_sum;
            pix_sum  <= video_de ? video_data : '0;
        end else if (video_de) begin
            pix_sum <= pix_sum + video_data;
        end
    end
`endif

endmodule

// File: doc/video_frame_tagger.md
VIDEO_FRAME_TAGGER -- requirements
Module: video_frame_tagger

Interface
REQ-001 Parameter HDR_MAGIC, default 16'hA55A, first header word of every frame.
REQ-002 Parameter EXP_WIDTH, default 1920, expected video_de-high cycles per line.
REQ-003 video_clk  in  1  sole clock; all logic on rising edge.
REQ-004 Reset  in  1  synchronous, active-high reset.
REQ-005 video_vs  in  1  one-cycle frame-start pulse.
REQ-006 video_de  in  1  pixel valid; a high run is one line.
REQ-007 video_data  in  16  RGB565 pixel word.
REQ-008 out_de  out  1  output word valid; drives video_recive video_de.
REQ-009 out_data  out  16  output word; drives video_recive video_data.
REQ-010 out_hdr  out  1  high when the out_data word is a header word.
REQ-011 frame_cnt  out  16  frames started since reset.
REQ-012 hdr_drop  out  1  one-cycle pulse when an unfinished header is discarded.

Function
REQ-013 The pixel path SHALL have a fixed 1-cycle latency: video_de=1 at cycle n -> out_de=1, out_data=video_data, out_hdr=0 at n+1.
REQ-014 The FSM SHALL have states IDLE (after reset, no header pending), HDR (header words pending) and RUN (header done).
REQ-015 video_vs in any state SHALL snapshot the statistics, increment frame_cnt (16'hFFFF wraps to 0), clear the live counters, set hdr_idx=0 and enter HDR.
REQ-016 In HDR, each cycle with video_de=0 SHALL emit header word hdr_idx at n+1 with out_de=1 and out_hdr=1, then increment hdr_idx.
REQ-017 In HDR, a cycle with video_de=1 SHALL pass the pixel and hold hdr_idx, so pixels always win over header words.
REQ-018 After the last header word is emitted, the FSM SHALL go HDR->RUN.
REQ-019 In IDLE and RUN, cycles with video_de=0 SHALL give out_de=0, out_hdr=0 and out_data holding its last value.
REQ-020 Header words: W0=HDR_MAGIC; W1=new frame_cnt; W2=lines of the previous frame; W3={line_err, last line length[14:0]} of the previous frame.
REQ-021 pix_cnt SHALL count video_de-high cycles in the current line and saturate at 15'h7FFF.
REQ-022 On each video_de falling edge, line_cnt SHALL increment (saturating at 16'hFFFF), last_len SHALL take pix_cnt, and pix_cnt SHALL clear.
REQ-023 A line with pix_cnt != EXP_WIDTH SHALL set the frame's line_err; line_err clears only on the video_vs snapshot.
REQ-024 A line still open when video_vs arrives SHALL count in the new frame, not be closed.
REQ-025 video_vs while in HDR SHALL drop the remaining words, pulse hdr_drop at n+1 and restart the header with the new frame data.
REQ-026 video_vs together with video_de=1 SHALL apply REQ-015 first; the pixel passes and counts into the new frame.
REQ-027 The statistics reported for the first frame SHALL be whatever was counted between reset and the first video_vs.

Reset
REQ-028 While Reset=1, out_de, out_data, out_hdr, frame_cnt and hdr_drop SHALL be 0.
REQ-029 While Reset=1, all counters, the snapshot registers and line_err SHALL be 0, and the FSM SHALL be in IDLE.
REQ-030 Reset asserted mid-header or mid-line SHALL abort the header or line with no further output; the next header appears only after a later video_vs.

Configuration
REQ-031 With FRAME_TAGGER_CHECKSUM_EN defined, a 16-bit wrapping sum of all pixel words of the previous frame SHALL be emitted as header word W4 (5-word header).
REQ-032 With FRAME_TAGGER_CHECKSUM_EN undefined, the header SHALL be W0-W3 only, with no summing logic.

Verification
REQ-033 Reset, video_vs, 8 idle cycles -> 4 header words A55A, 0001, 0000, 0000 on consecutive cycles with out_hdr=1, then out_de=0.
REQ-034 3 lines of 1920 pixels, then video_vs -> header A55A, 0002, 0003, 0780; line_err=0.
REQ-035 One line of 1919 pixels, then video_vs -> W3=877F (line_err=1, length 1919).
REQ-036 video_vs, 1 idle cycle, 5 pixel cycles, 3 idle cycles -> W0, pixels p0-p4 at 1-cycle latency, then W1-W3.
REQ-037 video_vs, 2 idle cycles, video_vs -> W0, W1, then hdr_drop pulse and a new 4-word header with W1=frame_cnt+1.
REQ-038 With FRAME_TAGGER_CHECKSUM_EN: frame of pixels 0001, 0002, FFFF, then video_vs -> W4=0002.
